// File: rtl/fifo_thresh_if.sv
// Handshake and status bundle between a FIFO user (master) and fifo_thresh (slave).
interface fifo_thresh_if #(
    parameter int DATA_SIZE = 10,
    parameter int ADDR_SIZE = 3
);
    logic                 push;
    logic                 pop;
    logic [DATA_SIZE-1:0] data_in;
    logic [DATA_SIZE-1:0] data_out;
    logic                 data_valid;
    logic [ADDR_SIZE:0]   count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output push, pop, data_in,
        input  data_out, data_valid, count, full, empty,
               almost_full, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, data_valid, count, full, empty,
               almost_full, almost_empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_thresh.sv
// Synchronous register-array FIFO with registered read data, occupancy thresholds
// and sticky overflow/underflow flags.
module fifo_thresh #(
    parameter int DATA_SIZE = 10,
    parameter int ADDR_SIZE = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input logic          clk,
    input logic          reset,
    fifo_thresh_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(AF_THRESH);
    localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(AE_THRESH);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_overflow_err;
    logic                 r_underflow_err;

    logic w_full;
    logic w_empty;
    logic w_pop_acc;
    logic w_push_acc;

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_pop_acc  = bus.pop & ~w_empty;
    // A full FIFO can still take a word when the same edge frees a slot.
    assign w_push_acc = bus.push & (~w_full | w_pop_acc);

    // Memory is deliberately not reset; contents are unreachable while empty.
    always_ff @(posedge clk) begin
        if (reset && w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_data_out      <= '0;
            r_data_valid    <= 1'b0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_data_valid <= w_pop_acc;
            if (w_pop_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - 1'b1;
            end
            if (bus.push && !w_push_acc) begin
                r_overflow_err <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign bus.data_out      = r_data_out;
    assign bus.data_valid    = r_data_valid;
    assign bus.count         = r_count;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.almost_full   = (r_count >= AF_C);
    assign bus.almost_empty  = (r_count <= AE_C);
    assign bus.overflow_err  = r_overflow_err;
    assign bus.underflow_err = r_underflow_err;
endmodule
